hex_monitor: RTL and testbench
==============================

Name: hex_monitor

Overview:
Observer/decoder for the 6-digit moving-segment display. It samples the six 8-bit HEX segment buses and decodes them back into position (0-5) and direction. It checks that each new frame is a legal step of the bounce sequence and counts steps, reversals and errors. It sits beside the display path and feeds board-level self-check LEDs and the simulation scoreboard.

Parameters:
SEG_SUS, 8'h01, pattern of the active digit while moving up (direction=1).
SEG_JOS, 8'h08, pattern of the active digit while moving down (direction=0).
ACTIVE_LOW, 0, 1 = segment inputs are active-low; they are inverted before decode.
NUM_POS, 6, number of digit positions. Positions are 0..NUM_POS-1.

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous, active-high reset
hex_i  input  48  {HEX5,HEX4,HEX3,HEX2,HEX1,HEX0}; HEX0 = bits [7:0]
sample_i  input  1  one-cycle strobe: evaluate the current hex_i snapshot
clr_i  input  1  synchronous clear of counters, error flag and tracking state
col_o  output  3  decoded position of the last valid frame
dir_o  output  1  decoded direction of the last valid frame (1=up, 0=down)
valid_o  output  1  the last sampled frame decoded legally
error_o  output  1  sticky: an illegal frame or illegal transition was seen
step_cnt_o  output  16  legal steps counted; saturates at 16'hFFFF
rev_cnt_o  output  8  direction reversals counted; saturates at 8'hFF
err_cnt_o  output  8  errors counted; saturates at 8'hFF

Behaviour:
- Reset (async, immediate): col_o=0, dir_o=0, valid_o=0, error_o=0, all counters 0, FSM=IDLE.
- All logic is clocked by clk_i. Inputs are evaluated only in a cycle where sample_i=1. All outputs update on the following clock edge (latency 1).
- Frame decode:
  - A frame is legal when exactly one digit is non-zero and that digit equals SEG_SUS or SEG_JOS.
  - col = index of that digit; dir = 1 for SEG_SUS, 0 for SEG_JOS.
  - Any other frame is illegal: multiple active digits, an unknown pattern, or all blank.
- Legal successor of (c,d):
  - up, c<NUM_POS-1 -> (c+1, up).
  - up, c=NUM_POS-1 -> (NUM_POS-2, down); this counts as a reversal.
  - down, c>0 -> (c-1, down).
  - down, c=0 -> (1, up); this counts as a reversal.
  - Repeating the same (c,d) is a hold: legal, no step counted.
- FSM states: IDLE, TRACK, ERR.
  - IDLE + legal frame -> TRACK. Latch col/dir, valid_o=1, no step counted.
  - IDLE + illegal frame -> ERR.
  - TRACK + legal successor -> TRACK. Latch the new col/dir and increment step_cnt_o. Also increment rev_cnt_o when dir changes.
  - TRACK + hold -> TRACK, with no counter change.
  - TRACK + legal frame that is not the successor -> ERR. Latch the new col/dir; valid_o stays 1.
  - Any state + illegal frame -> ERR with valid_o=0. col_o and dir_o hold.
  - Every entry into ERR, and every further bad frame while in ERR, sets error_o and increments err_cnt_o.
  - ERR + legal frame -> TRACK, re-synchronising on that frame. error_o stays set.
- All counters saturate and do not wrap.
- clr_i=1: next edge gives FSM=IDLE, error_o=0, all counters 0, valid_o=0. col_o and dir_o hold. clr_i has priority over a simultaneous sample_i, and that sample is discarded.
- A reset mid-operation discards any in-flight evaluation.
- hex_i must be stable in the sample_i cycle (same clock domain).

Optional Feature:
HEX_MONITOR_BLANK_OK_EN
- Defined: an all-blank frame is a legal "gap".
  - No state change and no counters touched.
  - valid_o=0 for that frame.
  - The tracked col/dir are kept, so the next frame is checked against the pre-gap position.
- Not defined: an all-blank frame is illegal, as listed above.

Test Plan:
- Reset, then frames (0,up),(1,up)…(5,up),(4,down)…(0,down),(1,up) -> step_cnt_o=11, rev_cnt_o=2, error_o=0, final col_o=1, dir_o=1.
- Legal frame (2,up) sampled three times -> step_cnt_o=0, valid_o=1, col_o=2.
- Track at (2,up), then frame (4,up) -> error_o=1, err_cnt_o=1, col_o=4; next (5,up) -> TRACK, step_cnt_o=1.
- Frame with HEX3=HEX1=SEG_SUS -> valid_o=0, error_o=1, col_o unchanged. Then clr_i with sample_i in the same cycle -> counters 0, error_o=0, FSM=IDLE.
- All-blank frame after (3,down): without macro -> err_cnt_o=1; with macro -> err_cnt_o=0, and (2,down) then counts step_cnt_o=1.
- Feed 70000 legal steps -> step_cnt_o=16'hFFFF, no wrap. Assert reset_i mid-run -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/hex_monitor.sv
// Observer/decoder for the 6-digit bouncing-segment display: decodes position and
// direction from the HEX buses, checks bounce legality, counts steps/reversals/errors.
// Optional build macro: HEX_MONITOR_BLANK_OK_EN (all-blank frame is a legal gap).
module hex_monitor #(
  parameter logic [7:0] SEG_SUS    = 8'h01,
  parameter logic [7:0] SEG_JOS    = 8'h08,
  parameter bit         ACTIVE_LOW = 1'b0,
  parameter int         NUM_POS    = 6
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [8*NUM_POS-1:0] hex_i,
  input  logic                 sample_i,
  input  logic                 clr_i,
  output logic [2:0]           col_o,
  output logic                 dir_o,
  output logic                 valid_o,
  output logic                 error_o,
  output logic [15:0]          step_cnt_o,
  output logic [7:0]           rev_cnt_o,
  output logic [7:0]           err_cnt_o,
  output logic [1:0]           state_o
);

  // Handshake: sample_i is a single-cycle strobe qualifying hex_i in that cycle;
  // clr_i in the same cycle wins and the sample is dropped. Results appear one edge later.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_POS = 3'(NUM_POS - 1);

`ifdef HEX_MONITOR_BLANK_OK_EN
  localparam bit BLANK_OK = 1'b1;
`else
  localparam bit BLANK_OK = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [2:0]  col_q, col_d;
  logic        dir_q, dir_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic [15:0] step_q, step_d;
  logic [7:0]  rev_q, rev_d;
  logic [7:0]  errc_q, errc_d;

  logic [8*NUM_POS-1:0] seg;
  logic [1:0]           n_active;
  logic                 frm_blank;
  logic                 frm_legal;
  logic [2:0]           frm_col;
  logic                 frm_dir;
  logic [7:0]           frm_pat;

  logic [2:0] succ_col;
  logic       succ_dir;
  logic       is_hold;
  logic       is_succ;

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign seg = ACTIVE_LOW ? ~hex_i : hex_i;

  // n_active saturates at 2: only "exactly one" matters.
  always_comb begin
    n_active  = 2'd0;
    frm_blank = 1'b1;
    frm_col   = 3'd0;
    frm_pat   = 8'h00;
    for (int i = 0; i < NUM_POS; i++) begin
      if (seg[8*i +: 8] != 8'h00) begin
        frm_blank = 1'b0;
        if (n_active != 2'd2) n_active = n_active + 2'd1;
        frm_col = 3'(i);
        frm_pat = seg[8*i +: 8];
      end
    end
    frm_legal = (n_active == 2'd1) && ((frm_pat == SEG_SUS) || (frm_pat == SEG_JOS));
    frm_dir   = (frm_pat == SEG_SUS);
  end

  always_comb begin
    succ_col = col_q;
    succ_dir = dir_q;
    if (dir_q) begin
      if (col_q == LAST_POS) begin
        succ_col = LAST_POS - 3'd1;
        succ_dir = 1'b0;
      end else begin
        succ_col = col_q + 3'd1;
      end
    end else begin
      if (col_q == 3'd0) begin
        succ_col = 3'd1;
        succ_dir = 1'b1;
      end else begin
        succ_col = col_q - 3'd1;
      end
    end
    is_hold = (frm_col == col_q) && (frm_dir == dir_q);
    is_succ = (frm_col == succ_col) && (frm_dir == succ_dir);
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    error_d = error_q;
    step_d  = step_q;
    rev_d   = rev_q;
    errc_d  = errc_q;
    if (clr_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      error_d = 1'b0;
      step_d  = 16'd0;
      rev_d   = 8'd0;
      errc_d  = 8'd0;
    end else if (sample_i) begin
      if (BLANK_OK && frm_blank) begin
        // Gap: tracking position is kept so the next frame is checked against it.
        valid_d = 1'b0;
      end else if (!frm_legal) begin
        state_d = ST_ERR;
        valid_d = 1'b0;
        error_d = 1'b1;
        errc_d  = sat8(errc_q);
      end else begin
        col_d   = frm_col;
        dir_d   = frm_dir;
        valid_d = 1'b1;
        case (state_q)
          ST_TRACK: begin
            if (is_succ) begin
              step_d = sat16(step_q);
              if (frm_dir != dir_q) rev_d = sat8(rev_q);
            end else if (!is_hold) begin
              state_d = ST_ERR;
              error_d = 1'b1;
              errc_d  = sat8(errc_q);
            end
          end
          ST_ERR: begin
            // A legal jump latched a valid position; its true successor still counts as a step.
            state_d = ST_TRACK;
            if (valid_q && is_succ) begin
              step_d = sat16(step_q);
              if (frm_dir != dir_q) rev_d = sat8(rev_q);
            end
          end
          default: state_d = ST_TRACK;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      col_q   <= 3'd0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      step_q  <= 16'd0;
      rev_q   <= 8'd0;
      errc_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      error_q <= error_d;
      step_q  <= step_d;
      rev_q   <= rev_d;
      errc_q  <= errc_d;
    end
  end

  assign col_o      = col_q;
  assign dir_o      = dir_q;
  assign valid_o    = valid_q;
  assign error_o    = error_q;
  assign step_cnt_o = step_q;
  assign rev_cnt_o  = rev_q;
  assign err_cnt_o  = errc_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_hex_monitor.sv
// Directed bench for hex_monitor: vector table plus saturation and async-reset sequences.
module tb_hex_monitor;

  logic        clk_i;
  logic        reset_i;
  logic [47:0] hex_i;
  logic        sample_i;
  logic        clr_i;
  logic [2:0]  col_o;
  logic        dir_o;
  logic        valid_o;
  logic        error_o;
  logic [15:0] step_cnt_o;
  logic [7:0]  rev_cnt_o;
  logic [7:0]  err_cnt_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_q[$];

  typedef struct {
    logic [47:0] hex;
    logic        smp;
    logic        clr;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam int T = 1;
  localparam int I = 0;
  localparam int E = 2;

  hex_monitor dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .hex_i      (hex_i),
    .sample_i   (sample_i),
    .clr_i      (clr_i),
    .col_o      (col_o),
    .dir_o      (dir_o),
    .valid_o    (valid_o),
    .error_o    (error_o),
    .step_cnt_o (step_cnt_o),
    .rev_cnt_o  (rev_cnt_o),
    .err_cnt_o  (err_cnt_o),
    .state_o    (state_o)
  );

  // clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [47:0] frm(input int c, input bit up);
    logic [47:0] h;
    h = '0;
    h[8*c +: 8] = up ? 8'h01 : 8'h08;
    return h;
  endfunction

  function automatic logic [39:0] ex(input int st, input int col, input bit dir, input bit v,
                                     input bit e, input int s, input int r, input int ec);
    return {2'(st), 3'(col), dir, v, e, 16'(s), 8'(r), 8'(ec)};
  endfunction

  function automatic void add(input logic [47:0] h, input logic s, input logic c,
                              input logic [39:0] e);
    vec_t v;
    v.hex = h;
    v.smp = s;
    v.clr = c;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic logic [39:0] actual();
    return {state_o, col_o, dir_o, valid_o, error_o, step_cnt_o, rev_cnt_o, err_cnt_o};
  endfunction

  task automatic drive(input logic [47:0] h, input logic s, input logic c);
    hex_i    = h;
    sample_i = s;
    clr_i    = c;
    @(posedge clk_i);
    #1;
    sample_i = 1'b0;
    clr_i    = 1'b0;
  endtask

  task automatic check(input string name);
    logic [39:0] e;
    logic [39:0] a;
    e = exp_q.pop_front();
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got st=%0d col=%0d dir=%0b v=%0b e=%0b step=%h rev=%h errc=%h want st=%0d col=%0d dir=%0b v=%0b e=%0b step=%h rev=%h errc=%h",
               name, a[39:38], a[37:35], a[34], a[33], a[32], a[31:16], a[15:8], a[7:0],
               e[39:38], e[37:35], e[34], e[33], e[32], e[31:16], e[15:8], e[7:0]);
    end
  endtask

  initial begin
    int c;
    bit d;
    int s_exp;
    int r_exp;

    reset_i  = 1'b1;
    hex_i    = '0;
    sample_i = 1'b0;
    clr_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    exp_q.push_back(ex(I, 0, 0, 0, 0, 0, 0, 0));
    check("reset_state");
    reset_i = 1'b0;

    // full bounce with both reversals
    add(frm(0, 1), 1, 0, ex(T, 0, 1, 1, 0, 0, 0, 0));
    add(frm(1, 1), 1, 0, ex(T, 1, 1, 1, 0, 1, 0, 0));
    add(frm(2, 1), 1, 0, ex(T, 2, 1, 1, 0, 2, 0, 0));
    add(frm(3, 1), 1, 0, ex(T, 3, 1, 1, 0, 3, 0, 0));
    add(frm(4, 1), 1, 0, ex(T, 4, 1, 1, 0, 4, 0, 0));
    add(frm(5, 1), 1, 0, ex(T, 5, 1, 1, 0, 5, 0, 0));
    add(frm(4, 0), 1, 0, ex(T, 4, 0, 1, 0, 6, 1, 0));
    add(frm(3, 0), 1, 0, ex(T, 3, 0, 1, 0, 7, 1, 0));
    add(frm(2, 0), 1, 0, ex(T, 2, 0, 1, 0, 8, 1, 0));
    add(frm(1, 0), 1, 0, ex(T, 1, 0, 1, 0, 9, 1, 0));
    add(frm(0, 0), 1, 0, ex(T, 0, 0, 1, 0, 10, 1, 0));
    add(frm(1, 1), 1, 0, ex(T, 1, 1, 1, 0, 11, 2, 0));
    // no strobe: garbage ignored
    add(48'h00FF_FF00_0000, 0, 0, ex(T, 1, 1, 1, 0, 11, 2, 0));
    add('0, 0, 1, ex(I, 1, 1, 0, 0, 0, 0, 0));
    // holds
    add(frm(2, 1), 1, 0, ex(T, 2, 1, 1, 0, 0, 0, 0));
    add(frm(2, 1), 1, 0, ex(T, 2, 1, 1, 0, 0, 0, 0));
    add(frm(2, 1), 1, 0, ex(T, 2, 1, 1, 0, 0, 0, 0));
    // jump, then its successor
    add(frm(4, 1), 1, 0, ex(E, 4, 1, 1, 1, 0, 0, 1));
    add(frm(5, 1), 1, 0, ex(T, 5, 1, 1, 1, 1, 0, 1));
    // illegal frames while tracking and while in error
    add(frm(3, 1) | frm(1, 1), 1, 0, ex(E, 5, 1, 0, 1, 1, 0, 2));
    add(48'h0000_0003_0000, 1, 0, ex(E, 5, 1, 0, 1, 1, 0, 3));
    add(frm(0, 1), 1, 1, ex(I, 5, 1, 0, 0, 0, 0, 0));
    add(frm(3, 0), 1, 0, ex(T, 3, 0, 1, 0, 0, 0, 0));
`ifdef HEX_MONITOR_BLANK_OK_EN
    add('0, 1, 0, ex(T, 3, 0, 0, 0, 0, 0, 0));
    add(frm(2, 0), 1, 0, ex(T, 2, 0, 1, 0, 1, 0, 0));
`else
    add('0, 1, 0, ex(E, 3, 0, 0, 1, 0, 0, 1));
    add(frm(2, 0), 1, 0, ex(T, 2, 0, 1, 1, 0, 0, 1));
`endif
    add('0, 0, 1, ex(I, 2, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].exp);
      drive(vecs[i].hex, vecs[i].smp, vecs[i].clr);
      check($sformatf("vec%0d", i));
    end

    // long run: step and reversal saturation
    c = 0;
    d = 1'b1;
    drive(frm(c, d), 1, 0);
    for (int k = 1; k <= 70000; k++) begin
      if (d) begin
        if (c == 5) begin c = 4; d = 1'b0; end
        else c = c + 1;
      end else begin
        if (c == 0) begin c = 1; d = 1'b1; end
        else c = c - 1;
      end
      drive(frm(c, d), 1, 0);
      if (k == 1275 || k == 1276 || k == 1281 || k == 65534 || k == 65535 ||
          k == 65536 || k == 70000) begin
        s_exp = (k > 65535) ? 65535 : k;
        r_exp = ((k - 1) / 5 > 255) ? 255 : (k - 1) / 5;
        exp_q.push_back(ex(T, c, d, 1, 0, s_exp, r_exp, 0));
        check($sformatf("sat_k%0d", k));
      end
    end

    // asynchronous reset between edges
    #2 reset_i = 1'b1;
    #1;
    exp_q.push_back(ex(I, 0, 0, 0, 0, 0, 0, 0));
    check("async_reset");
    @(posedge clk_i);
    #1 reset_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
